// File: rtl/mdu_pkg.sv
// Shared op codes and FSM state encodings
// for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between a requester
// and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       G;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Z;

  modport master (
    output start, flush, G, A, B,
    input  ready, done, Result, Z
  );

  modport slave (
    input  start, flush, G, A, B,
    output ready, done, Result, Z
  );
endinterface

// File: rtl/mdu_iter.sv
// One radix-2 step: shift-add multiply or
// restoring divide on unsigned magnitudes.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    shl  = {acc, mq[WIDTH-1]};
    diff = shl - {1'b0, opnd};
    if (is_div) begin
      // top bit of diff is the borrow: set when shl < divisor
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shl[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit:
// FSM, step counter and sign handling.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_e           state;
  op_e              op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             neg;
  logic             fast;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             done;
  logic             ready;

  logic             a_sgn, b_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             by_zero, ovf;
  logic             fast_in, neg_in;
  logic [WIDTH-1:0] fast_val;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      bus.G == MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
      bus.G == MULHSU: a_sgn = 1'b1;
      bus.G == DIV:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
      bus.G == REM:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default: ;
    endcase
    a_neg   = a_sgn & bus.A[WIDTH-1];
    b_neg   = b_sgn & bus.B[WIDTH-1];
    a_mag   = a_neg ? -bus.A : bus.A;
    b_mag   = b_neg ? -bus.B : bus.B;
    by_zero = bus.B == '0;
    ovf     = b_sgn & bus.G[2]
            & (bus.A == MIN) & (bus.B == '1);
    fast_in = bus.G[2] & (by_zero | ovf);
    // remainder follows the dividend sign only
    neg_in  = (bus.G[2] & bus.G[1]) ? a_neg
                                    : a_neg ^ b_neg;
    if (by_zero)
      fast_val = bus.G[1] ? bus.A : '1;
    else
      fast_val = bus.G[1] ? '0 : bus.A;
  end

  logic [WIDTH-1:0] acc_nxt, mq_nxt;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (op[2]),
    .acc     (acc),
    .mq      (mq),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quot_c, rem_c, res_fin;

  always_comb begin
    prod_c = neg ? -{acc, mq} : {acc, mq};
    quot_c = neg ? -mq : mq;
    rem_c  = neg ? -acc : acc;
    if (fast)
      res_fin = fast_res;
    else if (op[2])
      res_fin = op[1] ? rem_c : quot_c;
    else if (op == MUL)
      res_fin = prod_c[WIDTH-1:0];
    else
      res_fin = prod_c[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= MUL;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      neg      <= 1'b0;
      fast     <= 1'b0;
      fast_res <= '0;
      result   <= '0;
      z        <= 1'b1;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
        ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              op       <= op_e'(bus.G);
              acc      <= '0;
              mq       <= a_mag;
              opnd     <= b_mag;
              neg      <= neg_in;
              fast     <= fast_in;
              fast_res <= fast_val;
              cnt      <= '0;
              ready    <= 1'b0;
              state    <= fast_in ? FINISH : CALC;
            end
          end
          CALC: begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FINISH;
          end
          FINISH: begin
            result <= res_fin;
            z      <= res_fin == '0;
            done   <= 1'b1;
            ready  <= 1'b1;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.done   = done;
  assign bus.Result = result;
  assign bus.Z      = z;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32.
// Expected values are hand-computed constants.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic count_done(input int cycles,
                            output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  task automatic run_op(input logic [2:0] g,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat,
                        input string tag);
    int n;
    @(negedge clk);
    bus.G     = g;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, 64'(bus.Result), 64'(exp));
    chk({tag, "_z"}, 64'(bus.Z),
        64'(exp == 32'h0));
  endtask

  initial begin
    int n;
    int cnt;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.G     = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.Result), 64'd0);
    chk("rst_z", 64'(bus.Z), 64'd1);
    rst_n = 1'b1;

    run_op(MUL, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, 33, "mul");
    run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 33, "mulhu");
    run_op(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h00000000, 33, "mulh");
    run_op(MULHSU, 32'hFFFFFFFF, 32'd2,
           32'hFFFFFFFF, 33, "mulhsu");
    run_op(DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 33, "div");
    run_op(REM, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 33, "rem");
    run_op(DIVU, 32'h1234, 32'd0,
           32'hFFFFFFFF, 1, "divu_z");
    run_op(REMU, 32'h1234, 32'd0,
           32'h00001234, 1, "remu_z");
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 1, "div_ovf");
    run_op(REM, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 1, "rem_ovf");
    run_op(DIVU, 32'd100, 32'd7,
           32'd14, 33, "divu");
    run_op(REMU, 32'd100, 32'd7,
           32'd2, 33, "remu");

    // flush at E10, stray start at E5
    @(negedge clk);
    bus.G     = DIV;
    bus.A     = 32'd100;
    bus.B     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.G     = MUL;
    bus.A     = 32'd9;
    bus.B     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.ready), 64'd1);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_result", 64'(bus.Result), 64'd2);
    count_done(40, cnt);
    chk("flush_no_done", 64'(cnt), 64'd0);

    // back-to-back with start held across done
    @(negedge clk);
    bus.G     = MUL;
    bus.A     = 32'd3;
    bus.B     = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.A = 32'd6;
    bus.B = 32'd7;
    wait_done(n);
    chk("b2b1_lat", 64'(n), 64'd33);
    chk("b2b1_res", 64'(bus.Result), 64'd15);
    chk("b2b1_ready", 64'(bus.ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b2_busy", 64'(bus.ready), 64'd0);
    wait_done(n);
    chk("b2b2_lat", 64'(n), 64'd33);
    chk("b2b2_res", 64'(bus.Result), 64'd42);

    // reset mid-CALC
    @(negedge clk);
    bus.G     = DIVU;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstm_done", 64'(bus.done), 64'd0);
    chk("rstm_result", 64'(bus.Result), 64'd0);
    chk("rstm_ready", 64'(bus.ready), 64'd1);
    chk("rstm_z", 64'(bus.Z), 64'd1);
    count_done(40, cnt);
    chk("rstm_no_done", 64'(cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are even integers of 8 or more.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 start  input  1  is an operation request, accepted only when ready=1.
REQ-006 flush  input  1  aborts any operation in flight.
REQ-007 G  input  3  is the op code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 A  input  WIDTH  is operand A (multiplicand or dividend).
REQ-009 B  input  WIDTH  is operand B (multiplier or divisor).
REQ-010 ready  output  1  is high only in IDLE.
REQ-011 done  output  1  is a one-cycle pulse marking a valid Result.
REQ-012 Result  output  WIDTH  is the registered result.
REQ-013 Z  output  1  is high when the Result registered with done is all zeros.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FINISH.
REQ-015 IDLE->CALC SHALL occur on an edge with start=1 and flush=0 (the accept edge E0), capturing G, A and B; operands are ignored after E0.
REQ-016 CALC SHALL perform one radix-2 step per edge (shift-add multiply, restoring divide on magnitudes) on edges E1..E_WIDTH, then move to FINISH.
REQ-017 At edge E_WIDTH+1 the block SHALL apply sign correction, register Result and Z, return to IDLE, and assert done for exactly that one following cycle.
REQ-018 Normal latency SHALL be WIDTH+1 edges from accept to done (33 for WIDTH=32).
REQ-019 MUL SHALL return product bits [WIDTH-1:0]; MULH, MULHSU and MULHU SHALL return bits [2*WIDTH-1:WIDTH] with signed*signed, signed*unsigned and unsigned*unsigned interpretation respectively.
REQ-020 DIV and REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-021 Divide by zero SHALL give DIV/DIVU = all ones and REM/REMU = A; this is a fast path with Result registered at E1, done in the cycle after E1, and no CALC.
REQ-022 Signed overflow (A = most-negative, B = -1) SHALL give DIV = A and REM = 0 through the same fast path as REQ-021.
REQ-023 start while ready=0 SHALL be ignored and not queued.
REQ-024 flush=1 on any edge SHALL force IDLE, drop the operation and suppress done; flush takes priority over start on the same edge; Result keeps its prior value.
REQ-025 Result and Z SHALL hold their values from the last done until the next done.
REQ-026 A done cycle SHALL be followed by ready=1, so start can be accepted on the edge ending the done cycle.

Reset
REQ-027 On an edge with rst_n=0 the block SHALL enter IDLE, set ready=1 after reset, set done=0, Result=0 and Z=1, and clear the counter.
REQ-028 Reset SHALL override flush and start, and abort any operation in flight with no done.

Structure
REQ-029 A shared package mdu_pkg SHALL hold the op-code constants (MUL..REMU) and the state encodings (IDLE, CALC, FINISH).
REQ-030 The single-step shift/add/subtract datapath SHALL be the sub-module mdu_iter, parametrised by WIDTH; FSM, counter and sign handling stay in mul_div_unit.

Verification (WIDTH=32)
REQ-031 MUL A=7, B=0xFFFFFFFD -> Result 0xFFFFFFEB, done 33 edges after accept, Z=0.
REQ-032 MULHU A=B=0xFFFFFFFF -> Result 0xFFFFFFFE; MULH with the same operands -> 0x00000000 with Z=1.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-034 DIVU A=0x1234, B=0 -> 0xFFFFFFFF and REMU -> 0x1234, each with done on the cycle after E1; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 Start DIV, flush at E10 -> no done, ready=1 next cycle, Result unchanged; start at E5 during the operation is ignored.
REQ-036 Back-to-back: start held high across a done -> second op accepted on the edge ending the done cycle; rst_n=0 mid-CALC -> done=0, Result=0, ready=1.
